// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level configuration constants used when instantiating bus-side blocks.
package core_v_mini_mcu_pkg;

  localparam int unsigned FETCH_BUFFER_DEPTH = 32'd2;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus transfer types shared by the instruction-side masters and the system bus.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_fetch_buffer.sv
// Registered OBI request/response stage between the CPU fetch port and the bus,
// limiting the number of fetches in flight to DEPTH.
module obi_fetch_buffer
  import obi_pkg::*;
#(
  parameter int unsigned DEPTH = 32'd2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  obi_req_t                   core_req_i,
  output obi_resp_t                  core_resp_o,
  output obi_req_t                   bus_req_o,
  input  obi_resp_t                  bus_resp_i,
  output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
  output logic                       err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);

  if ((DEPTH < 32'd1) || (DEPTH > 32'd4)) begin : g_depth_check
    $error("obi_fetch_buffer: DEPTH must be in 1..4");
  end

  obi_req_t        held_r;
  obi_req_t        held_next_s;
  logic            rsp_valid_r;
  logic [31:0]     rsp_data_r;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            err_r;
  logic            core_gnt_s;
  logic            bus_accept_s;
  logic            unexpected_s;
  logic            cnt_dec_s;

  // Grant, slot, counter and error decisions for the current cycle.
  always_comb begin
    core_gnt_s   = 1'b0;
    bus_accept_s = 1'b0;
    unexpected_s = 1'b0;
    cnt_dec_s    = 1'b0;
    held_next_s  = held_r;
    cnt_next_s   = cnt_r;

    // Gated by rst_i so the CPU never sees a grant while the block is held in reset.
    core_gnt_s   = ~rst_i & core_req_i.req & (~held_r.req | bus_resp_i.gnt) & (cnt_r < DEPTH_C);
    bus_accept_s = held_r.req & bus_resp_i.gnt;
    // A response with nothing in flight and nothing waiting in the response register is spurious.
    unexpected_s = bus_resp_i.rvalid & (cnt_r == ZERO_C) & ~rsp_valid_r;
    cnt_dec_s    = rsp_valid_r & (cnt_r != ZERO_C);

    if (core_gnt_s) begin
      held_next_s     = core_req_i;
      held_next_s.req = 1'b1;
    end else if (bus_accept_s) begin
      held_next_s.req = 1'b0;
    end else begin
      held_next_s = held_r;
    end

    case ({core_gnt_s, cnt_dec_s})
      2'b10:   cnt_next_s = cnt_r + ONE_C;
      2'b01:   cnt_next_s = cnt_r - ONE_C;
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Held request slot driving the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_r <= '{req: 1'b0, addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0};
    end else begin
      held_r <= held_next_s;
    end
  end

  // Response register; OBI has no rready, so it loads every cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'h0;
    end else begin
      rsp_valid_r <= bus_resp_i.rvalid & ~unexpected_s;
      if (bus_resp_i.rvalid && !unexpected_s) begin
        rsp_data_r <= bus_resp_i.rdata;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  // Outstanding counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= ZERO_C;
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      err_r <= err_r | unexpected_s;
    end
  end

  assign bus_req_o          = held_r;
  assign core_resp_o.gnt    = core_gnt_s;
  assign core_resp_o.rvalid = rsp_valid_r;
  assign core_resp_o.rdata  = rsp_data_r;
  assign outstanding_o      = cnt_r;
  assign err_o              = err_r;

endmodule

// File: tb/tb_obi_fetch_buffer.sv
// Self-checking bench for obi_fetch_buffer: directed vector table, hand sequences
// and a randomized run against a transaction-level reference model.
module tb_obi_fetch_buffer;
  import obi_pkg::*;

  localparam int unsigned DEPTH_A = core_v_mini_mcu_pkg::FETCH_BUFFER_DEPTH;
  localparam int unsigned DEPTH_B = 32'd4;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  obi_req_t  core_req;
  obi_resp_t bus_resp;

  obi_resp_t core_resp_a, core_resp_b;
  obi_req_t  bus_req_a, bus_req_b;
  logic [$clog2(DEPTH_A+1)-1:0] out_a;
  logic [$clog2(DEPTH_B+1)-1:0] out_b;
  logic err_a, err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obi_fetch_buffer #(.DEPTH(DEPTH_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_resp_o(core_resp_a),
    .bus_req_o(bus_req_a), .bus_resp_i(bus_resp), .outstanding_o(out_a), .err_o(err_a)
  );

  obi_fetch_buffer #(.DEPTH(DEPTH_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .core_req_i(core_req), .core_resp_o(core_resp_b),
    .bus_req_o(bus_req_b), .bus_resp_i(bus_resp), .outstanding_o(out_b), .err_o(err_b)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        bgnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_gnt;
    logic        e_breq;
    logic [31:0] e_baddr;
    logic        e_rv;
    logic [31:0] e_rdata;
    int          e_out;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obi_req_t mk_req(input logic [31:0] addr, input logic we,
                                      input logic [3:0] be, input logic [31:0] wdata);
    obi_req_t r;
    r.req = 1'b1; r.addr = addr; r.we = we; r.be = be; r.wdata = wdata;
    return r;
  endfunction

  function automatic obi_resp_t mk_rsp(input logic gnt, input logic rv, input logic [31:0] rdata);
    obi_resp_t b;
    b.gnt = gnt; b.rvalid = rv; b.rdata = rdata;
    return b;
  endfunction

  function automatic logic [31:0] bus_data(input obi_req_t r);
    return r.addr ^ 32'h5A5A_0F0F;
  endfunction

  task automatic cyc(input obi_req_t r, input obi_resp_t b);
    @(negedge clk);
    core_req = r;
    bus_resp = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_req = '0;
    bus_resp = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state for the randomized run
  obi_req_t  pend_m;
  logic      pend_v_m;
  obi_req_t  infl_q [$];
  int        out_m;
  logic      rv_m;
  logic [31:0] rd_m;

  initial begin
    obi_req_t  s;
    obi_req_t  r;
    obi_resp_t b;
    logic      exp_gnt;
    logic      bus_rv;

    core_req = '0;
    core_req.req = 1'b1;
    bus_resp = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_core_resp", 96'(core_resp_a), 96'(0));
    check("reset_bus_req", 96'(bus_req_a), 96'(0));
    check("reset_out", 96'(out_a), 96'(0));
    check("reset_err", 96'(err_a), 96'(0));
    do_reset();

    // Single read, then filling DEPTH_A=2 while the bus withholds responses
    tbl[0]  = '{1'b1, 32'h180, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h180, 1'b0, 32'h0,         1};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'hDEADBEEF,  1};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         0};
    tbl[6]  = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         0};
    tbl[7]  = '{1'b1, 32'h204, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'h0,         1};
    tbl[8]  = '{1'b1, 32'h208, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, 1'b0, 32'h0,         2};
    tbl[9]  = '{1'b1, 32'h208, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         2};
    tbl[10] = '{1'b1, 32'h208, 1'b1, 1'b1, 32'h11111111,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         2};
    tbl[11] = '{1'b1, 32'h208, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h11111111,  2};
    tbl[12] = '{1'b1, 32'h208, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h208, 1'b0, 32'h0,         2};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h22222222,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         2};
    tbl[15] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h33333333,  1'b0, 1'b0, 32'h0,   1'b1, 32'h22222222,  2};
    tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h33333333,  1};
    tbl[17] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         0};

    for (int i = 0; i < 18; i++) begin
      r = tbl[i].req ? mk_req(tbl[i].addr, 1'b0, 4'hF, 32'h0) : obi_req_t'('0);
      cyc(r, mk_rsp(tbl[i].bgnt, tbl[i].rv, tbl[i].rdata));
      check($sformatf("tbl%0d_gnt", i), 96'(core_resp_a.gnt), 96'(tbl[i].e_gnt));
      check($sformatf("tbl%0d_breq", i), 96'(bus_req_a.req), 96'(tbl[i].e_breq));
      if (tbl[i].e_breq) check($sformatf("tbl%0d_baddr", i), 96'(bus_req_a.addr), 96'(tbl[i].e_baddr));
      check($sformatf("tbl%0d_rvalid", i), 96'(core_resp_a.rvalid), 96'(tbl[i].e_rv));
      if (tbl[i].e_rv) check($sformatf("tbl%0d_rdata", i), 96'(core_resp_a.rdata), 96'(tbl[i].e_rdata));
      check($sformatf("tbl%0d_out", i), 96'(out_a), 96'(tbl[i].e_out));
      check($sformatf("tbl%0d_err", i), 96'(err_a), 96'(0));
    end

    // Back-to-back reads on the DEPTH=4 instance: bus always grants, rvalid one cycle later
    do_reset();
    for (int i = 0; i < 8; i++) begin
      int exp_out [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
      r = (i < 4) ? mk_req(32'(4 * i), 1'b0, 4'hF, 32'h0) : obi_req_t'('0);
      cyc(r, mk_rsp(1'b1, (i >= 2) && (i <= 5), 32'h1000_0000 + 32'(4 * (i - 2))));
      if (i < 4) check($sformatf("b2b%0d_gnt", i), 96'(core_resp_b.gnt), 96'(1));
      check($sformatf("b2b%0d_breq", i), 96'(bus_req_b.req), 96'((i >= 1) && (i <= 4)));
      if ((i >= 1) && (i <= 4)) check($sformatf("b2b%0d_baddr", i), 96'(bus_req_b.addr), 96'(4 * (i - 1)));
      check($sformatf("b2b%0d_rvalid", i), 96'(core_resp_b.rvalid), 96'((i >= 3) && (i <= 6)));
      if ((i >= 3) && (i <= 6))
        check($sformatf("b2b%0d_rdata", i), 96'(core_resp_b.rdata), 96'(32'h1000_0000 + 32'(4 * (i - 3))));
      check($sformatf("b2b%0d_out", i), 96'(out_b), 96'(exp_out[i]));
    end

    // Bus stall: held write must stay frozen while gnt is low
    do_reset();
    s = mk_req(32'h300, 1'b1, 4'h3, 32'hCAFE_F00D);
    cyc(s, mk_rsp(1'b0, 1'b0, 32'h0));
    check("stall_first_gnt", 96'(core_resp_a.gnt), 96'(1));
    for (int i = 0; i < 5; i++) begin
      cyc(mk_req(32'h400, 1'b0, 4'hF, 32'h0), mk_rsp(1'b0, 1'b0, 32'h0));
      check($sformatf("stall%0d_bus", i), 96'(bus_req_a), 96'(s));
      check($sformatf("stall%0d_gnt", i), 96'(core_resp_a.gnt), 96'(0));
    end
    cyc('0, mk_rsp(1'b1, 1'b0, 32'h0));
    check("stall_release_bus", 96'(bus_req_a), 96'(s));
    cyc('0, mk_rsp(1'b0, 1'b1, 32'h5));
    check("stall_cleared", 96'(bus_req_a.req), 96'(0));
    cyc('0, '0);
    check("stall_wr_rvalid", 96'(core_resp_a.rvalid), 96'(1));
    check("stall_wr_rdata", 96'(core_resp_a.rdata), 96'(32'h5));
    cyc('0, '0);
    check("stall_out", 96'(out_a), 96'(0));

    // Randomized traffic against the transaction-level model
    do_reset();
    pend_v_m = 1'b0; pend_m = '0; out_m = 0; rv_m = 1'b0; rd_m = 32'h0;
    infl_q.delete();
    for (int n = 0; n < 400; n++) begin
      r = mk_req($urandom, 1'($urandom), 4'($urandom), $urandom);
      r.req = ($urandom_range(0, 9) < 7);
      bus_rv = (infl_q.size() > 0) && ($urandom_range(0, 2) == 0);
      b = mk_rsp($urandom_range(0, 9) < 6, bus_rv, bus_rv ? bus_data(infl_q[0]) : $urandom);
      cyc(r, b);
      exp_gnt = r.req && (!pend_v_m || b.gnt) && (out_m < int'(DEPTH_A));
      check($sformatf("rnd%0d_gnt", n), 96'(core_resp_a.gnt), 96'(exp_gnt));
      check($sformatf("rnd%0d_breq", n), 96'(bus_req_a.req), 96'(pend_v_m));
      if (pend_v_m) check($sformatf("rnd%0d_bus", n), 96'(bus_req_a), 96'(pend_m));
      check($sformatf("rnd%0d_rvalid", n), 96'(core_resp_a.rvalid), 96'(rv_m));
      if (rv_m) check($sformatf("rnd%0d_rdata", n), 96'(core_resp_a.rdata), 96'(rd_m));
      check($sformatf("rnd%0d_out", n), 96'(out_a), 96'(out_m));
      check($sformatf("rnd%0d_err", n), 96'(err_a), 96'(0));
      if (pend_v_m && b.gnt) begin
        infl_q.push_back(pend_m);
        pend_v_m = 1'b0;
      end
      if (exp_gnt) begin
        pend_m = r;
        pend_v_m = 1'b1;
      end
      if (bus_rv) void'(infl_q.pop_front());
      out_m = out_m + int'(exp_gnt) - int'(rv_m);
      rv_m = bus_rv;
      rd_m = b.rdata;
    end

    // Unexpected response: dropped, err sticky through later traffic
    do_reset();
    cyc('0, mk_rsp(1'b0, 1'b1, 32'h99));
    check("err_before", 96'(err_a), 96'(0));
    cyc('0, '0);
    check("err_drop_rvalid", 96'(core_resp_a.rvalid), 96'(0));
    check("err_set", 96'(err_a), 96'(1));
    check("err_out", 96'(out_a), 96'(0));
    cyc(mk_req(32'h600, 1'b0, 4'hF, 32'h0), '0);
    check("err_traffic_gnt", 96'(core_resp_a.gnt), 96'(1));
    cyc('0, mk_rsp(1'b1, 1'b0, 32'h0));
    check("err_traffic_breq", 96'(bus_req_a.req), 96'(1));
    cyc('0, mk_rsp(1'b0, 1'b1, 32'h77));
    cyc('0, '0);
    check("err_traffic_rvalid", 96'(core_resp_a.rvalid), 96'(1));
    check("err_traffic_rdata", 96'(core_resp_a.rdata), 96'(32'h77));
    check("err_held", 96'(err_a), 96'(1));
    cyc('0, '0);
    check("err_traffic_out", 96'(out_a), 96'(0));

    // Reset mid-flight with the held slot full and one outstanding
    cyc(mk_req(32'h700, 1'b0, 4'hF, 32'h1234), '0);
    check("mid_gnt", 96'(core_resp_a.gnt), 96'(1));
    cyc(mk_req(32'h704, 1'b0, 4'hF, 32'h0), '0);
    check("mid_breq", 96'(bus_req_a.req), 96'(1));
    check("mid_out", 96'(out_a), 96'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_bus", 96'(bus_req_a), 96'(0));
    check("mid_rst_core", 96'(core_resp_a), 96'(0));
    check("mid_rst_out", 96'(out_a), 96'(0));
    check("mid_rst_err", 96'(err_a), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    core_req = mk_req(32'h800, 1'b0, 4'hF, 32'h0);
    bus_resp = '0;
    #1;
    check("post_rst_gnt", 96'(core_resp_a.gnt), 96'(1));
    check("post_rst_out", 96'(out_a), 96'(0));
    check("post_rst_bus", 96'(bus_req_a.req), 96'(0));
    cyc('0, '0);
    check("post_rst_breq", 96'(bus_req_a.req), 96'(1));
    check("post_rst_baddr", 96'(bus_req_a.addr), 96'(32'h800));
    check("post_rst_out1", 96'(out_a), 96'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
